// File: rtl/instr_fetch.sv
// Fetch stage: issues word reads to instruction memory and streams (pc, instr) pairs to decode through a 2-entry queue.
// Define FETCH_MISALIGN_CHECK_EN to flag redirect targets with nonzero low bits on misalign_err.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      fifo_q [0:1];
  entry_t      fifo_d [0:1];
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;

  logic        redir;
  logic [31:0] redir_addr;
  logic        pop;
  logic        push;
  logic        issue;

  assign redir      = reset & redirect_valid;
  assign redir_addr = {redirect_pc[31:2], 2'b00};

  assign if_valid = (count_q != 2'd0);
  assign if_pc    = if_valid ? fifo_q[rd_ptr_q].pc    : 32'h0;
  assign if_instr = if_valid ? fifo_q[rd_ptr_q].instr : 32'h0;

  // A redirect drops the response arriving in its own cycle, so no separate kill state is kept.
  assign pop   = if_valid & if_ready & ~redir;
  assign push  = inflight_q & ~redir;
  assign issue = redir |
                 (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

  assign imem_req  = reset & issue;
  assign imem_addr = redir ? redir_addr : pc_q;

  always_comb begin
    fifo_d        = fifo_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pc_d          = pc_q;
    inflight_d    = imem_req;
    inflight_pc_d = imem_addr;

    if (imem_req) begin
      pc_d = imem_addr + 32'd4;
    end

    if (redir) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        fifo_d[wr_ptr_q] = '{pc: inflight_pc_q, instr: imem_rdata};
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      count_q       <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= redir & (redirect_pc[1:0] != 2'b00);
    end
  end

  assign misalign_err = misalign_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign misalign_err         = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected pcs, a negedge monitor checks every accepted word.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .misalign_err   (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Synchronous instruction memory: data one cycle after an accepted request.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got pc %h expected no output", if_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_instr", if_instr, mem_word(e));
      end
    end
  end

  task automatic release_rst();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, "_valid"}, if_valid, 0);
    chk({name, "_req"}, imem_req, 0);
    chk({name, "_addr"}, imem_addr, 32'h0);
    chk({name, "_pc"}, if_pc, 32'h0);
    chk({name, "_instr"}, if_instr, 32'h0);
    chk({name, "_mis"}, misalign_err, 0);
  endtask

  task automatic end_scn(input string name);
    #2;
    chk({name, "_drain"}, 32'(exp_q.size()), 32'h0);
    exp_q.delete();
    reset = 1'b0;
    #1;
    chk_reset_state({name, "_rst"});
    redirect_valid = 1'b0;
    if_ready = 1'b1;
  endtask

  logic [31:0] exp_mis;

  initial begin
`ifdef FETCH_MISALIGN_CHECK_EN
    exp_mis = 32'h1;
`else
    exp_mis = 32'h0;
`endif
    #2;
    chk_reset_state("init");

    // Streaming from reset with decode always ready.
    exp_seq(32'h0, 8);
    release_rst();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k < 4) begin
        chk("s1_req", imem_req, 1);
        chk("s1_addr", imem_addr, 32'(4 * k));
      end
      if (k == 1) chk("s1_nvalid", if_valid, 0);
      if (k == 2) chk("s1_valid", if_valid, 1);
      if (k < 9) nxt();
    end
    end_scn("s1");

    // Backpressure for six cycles after first valid.
    if_ready = 1'b0;
    exp_seq(32'h0, 5);
    release_rst();
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 7) begin
        chk("s2_req_hold", imem_req, 0);
        chk("s2_pc_hold", if_pc, 32'h0);
        chk("s2_valid_hold", if_valid, 1);
      end
      if (k == 8) begin
        chk("s2_req_resume", imem_req, 1);
        chk("s2_addr_resume", imem_addr, 32'h8);
      end
      if (k < 12) begin
        nxt();
        if (k == 7) if_ready = 1'b1;
      end
    end
    end_scn("s2");

    // Redirect to 0x100 while streaming.
    exp_seq(32'h0, 3);
    exp_seq(32'h100, 3);
    release_rst();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 5) begin
        chk("s3_req", imem_req, 1);
        chk("s3_addr", imem_addr, 32'h100);
      end
      if (k == 6) chk("s3_nvalid", if_valid, 0);
      if (k == 7) chk("s3_pc", if_pc, 32'h100);
      if (k < 9) begin
        nxt();
        redirect_valid = (k == 4);
        redirect_pc    = 32'h100;
      end
    end
    end_scn("s3");

    // Redirect to 0x200 with the queue full and decode stalled.
    if_ready = 1'b0;
    exp_seq(32'h200, 3);
    release_rst();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 4) begin
        chk("s4_full_valid", if_valid, 1);
        chk("s4_req", imem_req, 1);
        chk("s4_addr", imem_addr, 32'h200);
      end
      if (k == 5) chk("s4_nvalid", if_valid, 0);
      if (k == 6) begin
        chk("s4_valid", if_valid, 1);
        chk("s4_pc", if_pc, 32'h200);
      end
      if (k < 9) begin
        nxt();
        redirect_valid = (k == 3);
        redirect_pc    = 32'h200;
        if (k == 6) if_ready = 1'b1;
      end
    end
    end_scn("s4");

    // Redirect to the top word; pc wraps to zero.
    exp_seq(32'hFFFF_FFFC, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    release_rst();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("s5_addr_top", imem_addr, 32'hFFFF_FFFC);
      if (k == 1) begin
        chk("s5_addr_wrap", imem_addr, 32'h0);
        chk("s5_nvalid", if_valid, 0);
      end
      if (k < 4) begin
        nxt();
        redirect_valid = 1'b0;
      end
    end
    end_scn("s5");

    // Reset pulse mid-stream, then restart from RESET_PC.
    exp_seq(32'h0, 3);
    release_rst();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 4) nxt();
    end
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("s6_mid");
    chk("s6_drain", 32'(exp_q.size()), 32'h0);
    exp_seq(32'h0, 2);
    release_rst();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("s6_req", imem_req, 1);
        chk("s6_addr", imem_addr, 32'h0);
      end
      if (k < 3) nxt();
    end
    end_scn("s6");

    // Misaligned redirect to 0x102 fetches from 0x100.
    exp_seq(32'h0, 1);
    exp_seq(32'h100, 2);
    release_rst();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chk("s7_mis_pre", misalign_err, 0);
        chk("s7_addr", imem_addr, 32'h100);
      end
      if (k == 4) begin
        chk("s7_mis", misalign_err, exp_mis);
        chk("s7_nvalid", if_valid, 0);
      end
      if (k == 5) begin
        chk("s7_mis_post", misalign_err, 0);
        chk("s7_pc", if_pc, 32'h100);
      end
      if (k < 6) begin
        nxt();
        redirect_valid = (k == 2);
        redirect_pc    = 32'h102;
      end
    end
    end_scn("s7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

endmodule
